// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the M-stage exception unit: CP0 exception codes,
// the exception vector and the Status/Cause bit positions.
package exc_ctrl_pkg;

  localparam logic [31:0] EXC_VECTOR = 32'hbfc0_0380;
  localparam logic [31:0] ZERO       = 32'h0000_0000;

  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_BP   = 32'h0000_0009;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int IM_HI      = 15;
  localparam int IM_LO      = 8;
  localparam int CAUSE_BD   = 31;

  typedef enum logic [1:0] {
    BAD_NONE = 2'd0,
    BAD_PC   = 2'd1,
    BAD_DATA = 2'd2
  } bad_sel_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REPORTED = 1'b1
  } state_e;

  // An interrupt is taken when an enabled line is pending, IE is set and EXL is clear.
  function automatic logic int_request(input logic [7:0] im, input logic [7:0] ip,
                                       input logic ie, input logic exl);
    return (|(im & ip)) & ie & ~exl;
  endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// M-stage exception interface: pipeline/CP0 inputs towards the exception
// unit and the CP0 exception report, flush and redirect coming back.
interface exc_ctrl_if;
  logic        stallM;
  logic        valid_instM;
  logic [31:0] pcM;
  logic        is_in_delayslotM;
  logic        adel_fetchM;
  logic        riM;
  logic        ovM;
  logic        syscallM;
  logic        breakM;
  logic        adel_dataM;
  logic        ades_dataM;
  logic        eretM;
  logic [31:0] data_addrM;
  logic [31:0] status_i;
  logic [31:0] cause_i;
  logic [31:0] epc_i;
  logic [31:0] excepttype_o;
  logic [31:0] current_inst_addr_o;
  logic        is_in_delayslot_o;
  logic [31:0] bad_addr_o;
  logic        flush_o;
  logic [31:0] newpc_o;
  logic        mem_kill_o;

  modport master (
    output stallM, valid_instM, pcM, is_in_delayslotM, adel_fetchM, riM, ovM,
           syscallM, breakM, adel_dataM, ades_dataM, eretM, data_addrM,
           status_i, cause_i, epc_i,
    input  excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o,
           flush_o, newpc_o, mem_kill_o
  );

  modport slave (
    input  stallM, valid_instM, pcM, is_in_delayslotM, adel_fetchM, riM, ovM,
           syscallM, breakM, adel_dataM, ades_dataM, eretM, data_addrM,
           status_i, cause_i, epc_i,
    output excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o,
           flush_o, newpc_o, mem_kill_o
  );
endinterface

// File: rtl/exc_ctrl_prio.sv
// Combinational exception priority encoder: picks the winning exception code
// of the M-stage instruction and tells which address is the faulting one.
module exc_prio
  import exc_ctrl_pkg::*;
(
  input  logic        valid_inst,
  input  logic        int_pend,
  input  logic        adel_fetch,
  input  logic        ri,
  input  logic        ov,
  input  logic        syscall,
  input  logic        brk,
  input  logic        adel_data,
  input  logic        ades_data,
  input  logic        eret,
  output logic [31:0] raw_code,
  output bad_sel_e    bad_sel
);

  // First match wins; bubbles never raise an exception.
  always_comb begin
    raw_code = ZERO;
    bad_sel  = BAD_NONE;
    if (!valid_inst) begin
      raw_code = ZERO;
    end else if (int_pend) begin
      raw_code = EXC_INT;
    end else if (adel_fetch) begin
      raw_code = EXC_ADEL;
      bad_sel  = BAD_PC;
    end else if (ri) begin
      raw_code = EXC_RI;
    end else if (ov) begin
      raw_code = EXC_OV;
    end else if (syscall) begin
      raw_code = EXC_SYS;
    end else if (brk) begin
      raw_code = EXC_BP;
    end else if (adel_data) begin
      raw_code = EXC_ADEL;
      bad_sel  = BAD_DATA;
    end else if (ades_data) begin
      raw_code = EXC_ADES;
      bad_sel  = BAD_DATA;
    end else if (eret) begin
      raw_code = EXC_ERET;
    end else begin
      raw_code = ZERO;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// M-stage exception controller: samples interrupts, reports each exception or
// ERET to CP0 exactly once and holds flush/redirect across memory stalls.
module exc_ctrl
  import exc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  exc_ctrl_if.slave  bus
);

  state_e      state_r, state_next_s;
  logic        int_pend_r;
  logic [31:0] raw_code_s;
  bad_sel_e    bad_sel_s;
  logic [31:0] raw_newpc_s, raw_bad_s;
  logic [31:0] newpc_lat_r, bad_lat_r;
  logic        capture_s;

  logic [31:0] excepttype_s, cia_s, bad_addr_s, newpc_s;
  logic        ds_s, flush_s, kill_s;

  logic unused_bits_s;
  assign unused_bits_s = ^{bus.status_i[31:16], bus.status_i[7:2],
                           bus.cause_i[31:16], bus.cause_i[7:0]};

  exc_prio u_prio (
    .valid_inst (bus.valid_instM),
    .int_pend   (int_pend_r),
    .adel_fetch (bus.adel_fetchM),
    .ri         (bus.riM),
    .ov         (bus.ovM),
    .syscall    (bus.syscallM),
    .brk        (bus.breakM),
    .adel_data  (bus.adel_dataM),
    .ades_data  (bus.ades_dataM),
    .eret       (bus.eretM),
    .raw_code   (raw_code_s),
    .bad_sel    (bad_sel_s)
  );

  // Redirect target and faulting address implied by the raw code.
  always_comb begin
    raw_newpc_s = ZERO;
    raw_bad_s   = ZERO;
    if (raw_code_s == ZERO) begin
      raw_newpc_s = ZERO;
    end else if (raw_code_s == EXC_ERET) begin
      raw_newpc_s = bus.epc_i;
    end else begin
      raw_newpc_s = EXC_VECTOR;
    end
    case (bad_sel_s)
      BAD_PC:   raw_bad_s = bus.pcM;
      BAD_DATA: raw_bad_s = bus.data_addrM;
      default:  raw_bad_s = ZERO;
    endcase
  end

  // Interrupt request sampled one cycle ahead of use.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      int_pend_r <= 1'b0;
    end else begin
      int_pend_r <= int_request(bus.status_i[IM_HI:IM_LO], bus.cause_i[IM_HI:IM_LO],
                                bus.status_i[STATUS_IE], bus.status_i[STATUS_EXL]);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  assign capture_s = (state_r == ST_IDLE) && (raw_code_s != ZERO) && bus.stallM;

  // Redirect and bad address frozen when the report is held by a stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      newpc_lat_r <= ZERO;
      bad_lat_r   <= ZERO;
    end else if (capture_s) begin
      newpc_lat_r <= raw_newpc_s;
      bad_lat_r   <= raw_bad_s;
    end else begin
      newpc_lat_r <= newpc_lat_r;
      bad_lat_r   <= bad_lat_r;
    end
  end

  // Next state and outputs; a held report keeps flushing but never re-commits CP0.
  always_comb begin
    state_next_s = state_r;
    excepttype_s = ZERO;
    cia_s        = ZERO;
    ds_s         = 1'b0;
    bad_addr_s   = ZERO;
    flush_s      = 1'b0;
    newpc_s      = ZERO;
    kill_s       = 1'b0;
    if (!rst) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (raw_code_s != ZERO) begin
            excepttype_s = raw_code_s;
            cia_s        = bus.pcM;
            ds_s         = bus.is_in_delayslotM;
            bad_addr_s   = raw_bad_s;
            flush_s      = 1'b1;
            newpc_s      = raw_newpc_s;
            kill_s       = 1'b1;
            state_next_s = bus.stallM ? ST_REPORTED : ST_IDLE;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_REPORTED: begin
          bad_addr_s   = bad_lat_r;
          flush_s      = 1'b1;
          newpc_s      = newpc_lat_r;
          kill_s       = 1'b1;
          state_next_s = bus.stallM ? ST_REPORTED : ST_IDLE;
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.excepttype_o        = excepttype_s;
  assign bus.current_inst_addr_o = cia_s;
  assign bus.is_in_delayslot_o   = ds_s;
  assign bus.bad_addr_o          = bad_addr_s;
  assign bus.flush_o             = flush_s;
  assign bus.newpc_o             = newpc_s;
  assign bus.mem_kill_o          = kill_s;

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
Exception detection and prioritisation unit in the M stage. It drives the exception inputs of the CP0 register block: `excepttype`, instruction address, delay-slot flag and bad address.
- Merges per-instruction exception flags with the pending hardware/timer interrupt.
- Issues the pipeline flush and redirect PC.
- Guarantees each exception/eret is reported to CP0 exactly once, even while the AXI memory stall (`stallM`) holds the M stage.

Parameters:
EXC_VECTOR, 32'hbfc00380, exception entry PC driven on `newpc_o`
ZERO, 32'h0, no-exception code

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
stallM  in  1  M stage held by memory
valid_instM  in  1  M stage holds a real instruction (not a bubble)
pcM  in  32  PC of the M-stage instruction
is_in_delayslotM  in  1  M instruction is in a branch delay slot
adel_fetchM  in  1  misaligned instruction fetch
riM  in  1  reserved instruction
ovM  in  1  arithmetic overflow
syscallM  in  1  SYSCALL
breakM  in  1  BREAK
adel_dataM  in  1  misaligned load
ades_dataM  in  1  misaligned store
eretM  in  1  ERET
data_addrM  in  32  data access address
status_i  in  32  CP0 Status
cause_i  in  32  CP0 Cause
epc_i  in  32  CP0 EPC
excepttype_o  out  32  exception code to CP0
current_inst_addr_o  out  32  equals pcM
is_in_delayslot_o  out  1  equals is_in_delayslotM
bad_addr_o  out  32  faulting address
flush_o  out  1  flush F/D/E/M, redirect PC
newpc_o  out  32  redirect target
mem_kill_o  out  1  suppress data-memory request of the M instruction

Behaviour:
- Reset (rst=0, async): state IDLE, `int_pend`=0, all outputs 0.
- Interrupt sampling (registered, 1-cycle latency):
  - `int_pend` <= |(cause_i[15:8] & status_i[15:8]) & status_i[0] & ~status_i[1]`.
  - The interrupt attaches only to a valid M instruction.
- Raw code, combinational, first match wins, only when valid_instM=1:
  1. int_pend -> 0x1
  2. adel_fetchM -> 0x4
  3. riM -> 0xa
  4. ovM -> 0xc
  5. syscallM -> 0x8
  6. breakM -> 0x9
  7. adel_dataM -> 0x4
  8. ades_dataM -> 0x5
  9. eretM -> 0xe
  10. otherwise ZERO
- `bad_addr_o`: pcM when the winning code comes from adel_fetchM, data_addrM for data AdEL/AdES, else 0.
- `current_inst_addr_o` passes pcM unmodified; CP0 applies the delay-slot -4 itself.
- `newpc_o`: epc_i when raw=0xe, else EXC_VECTOR; 0 when raw=ZERO.
- `mem_kill_o` = (raw != ZERO), including the eret case.
- FSM IDLE / REPORTED:
  - IDLE, raw != ZERO: `excepttype_o`=raw and `flush_o`=1 this cycle.
    - If stallM=1 -> REPORTED.
    - If stallM=0, stay IDLE. The flush removes the instruction, so the next cycle carries a new one.
  - REPORTED: `excepttype_o`=ZERO, because CP0 must not re-commit EPC/Cause. `flush_o`=1 and `newpc_o` stay held from the latched values.
    - stallM=0 -> IDLE.
    - Latched code, newpc and bad address are captured on the IDLE->REPORTED transition.
  - IDLE, raw=ZERO: all outputs 0.
- Input changes while REPORTED are ignored; the latched values win.
- Reset mid-REPORTED returns to IDLE immediately with outputs 0.
- An interrupt arriving while REPORTED is deferred; it is evaluated in IDLE.

Decomposition:
- Shared package/header `exc_defs`:
  - exception code constants: EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV, EXC_ERET.
  - EXC_VECTOR.
  - Status/Cause bit-index constants: IE=0, EXL=1, IM/IP=15:8, BD=31.
- One sub-module `exc_prio`: purely combinational priority encoder producing raw code and bad-address select.
- FSM and interrupt register live in `exc_ctrl`.

Test Plan:
- Reset low mid-REPORTED -> next edge-independent: all outputs 0, state IDLE.
- ovM=1, syscallM=1, pcM=0xbfc00100, stallM=0 -> one cycle: excepttype_o=0xc, flush_o=1, newpc_o=0xbfc00380, mem_kill_o=1.
- adel_dataM=1, data_addrM=0x80001003, stallM=1 for 3 cycles -> cycle 1: excepttype_o=0x4, bad_addr_o=0x80001003; cycles 2-3: excepttype_o=0, flush_o=1; after stallM falls, flush_o=0.
- status_i=0x0000_0401, cause_i IP2=1 (0x400), valid_instM=1 -> one cycle later excepttype_o=0x1. Repeat with status_i[1]=1 -> no exception.
- eretM=1, epc_i=0xbfc00704 -> excepttype_o=0xe, newpc_o=0xbfc00704, flush_o=1.
- adel_fetchM=1 with riM=1, valid_instM=0 -> all outputs 0. Repeat with valid_instM=1 -> excepttype_o=0x4, bad_addr_o=pcM.
